csa_acc_ctrl: RTL and testbench
===============================

# csa_acc_ctrl

Sequencer that accumulates a stream of N operands through one shared carry-save adder (the existing `CSA` module), keeping the running sum in redundant (partial-sum, shifted-carry) form. It resolves the sum with a chunked carry-propagate add and returns the result over a valid/ready handshake. It sits between an operand producer (e.g. the correlated-randomness expansion path) and any consumer that needs the modular sum mod 2^LEN of a batch.

## Interface
Parameters:
- LEN, 128, datapath width in bits; sum is taken mod 2^LEN.
- CHUNK, 32, carry-propagate chunk width; LEN must be a multiple of CHUNK.
- NOPS_W, 8, width of the operand-count field.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  job request; accepted only in IDLE.
- nops_i  in  NOPS_W  number of operands in the job; sampled with start_i.
- op_valid_i  in  1  operand valid.
- op_i  in  LEN  operand.
- op_ready_o  out  1  operand accepted when op_valid_i & op_ready_o.
- res_valid_o  out  1  result valid.
- res_o  out  LEN  resolved sum.
- res_ready_i  in  1  result consumed when res_valid_o & res_ready_i.
- busy_o  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ACCUM, RESOLVE, DONE.
- **IDLE**
  - ps, sc and remaining-count are held at 0.
  - On start_i: remaining ← nops_i, ps ← 0, sc ← 0.
  - Next state is ACCUM if nops_i ≠ 0, else RESOLVE.
- **ACCUM**
  - op_ready_o = 1.
  - On each handshake, CSA(a = ps, b = sc, c = op_i) is applied: ps ← ps_o, sc ← {sc_o[LEN-2:0], 1'b0}. The top carry bit is dropped (mod 2^LEN).
  - remaining decrements on each handshake; the handshake at remaining = 1 moves the FSM to RESOLVE.
  - Cycles without a handshake change nothing.
- **RESOLVE**
  - Runs LEN/CHUNK cycles, least-significant chunk first, with a chunk index counter and a 1-bit carry register.
  - Chunk i: res[i] ← ps[i] + sc[i] + carry; carry ← chunk carry-out.
  - The carry is cleared on entry to RESOLVE and discarded after the last chunk.
  - After the last chunk the FSM moves to DONE.
- **DONE**
  - res_valid_o = 1; res_o is stable.
  - On res_ready_i the FSM moves to IDLE.
- start_i is ignored while busy_o = 1.
- op_valid_i outside ACCUM is ignored; op_ready_o = 0 outside ACCUM.
- Asynchronous reset in any state: FSM goes to IDLE and all registers (ps, sc, res, counters, carry) clear to 0. An in-flight job is lost and no result is produced.

## Timing
- Reset values: op_ready_o = 0, res_valid_o = 0, res_o = 0, busy_o = 0.
- start_i accepted at cycle t → busy_o = 1 and op_ready_o = 1 (for nops ≠ 0) from cycle t+1.
- Accumulation throughput: 1 operand per cycle; no bubble between consecutive operands.
- Last operand accepted at cycle k → RESOLVE occupies k+1 .. k+LEN/CHUNK → res_valid_o = 1 from cycle k+LEN/CHUNK+1.
  - With defaults this is k+5.
  - nops = 0: res_valid_o = 1 at t+LEN/CHUNK+1, with res_o = 0.
- Result handshake at cycle d → IDLE at d+1. A new start_i is accepted from d+1 (1-cycle turnaround); it is not accepted in the same cycle as the result handshake.
- res_o and res_valid_o are registered outputs; no combinational path from any input to any output except op_ready_o and busy_o, which are decoded from state only.
- Maximum job size is 2^NOPS_W − 1 operands; no overflow of the operand count is possible.

## Structure
- Package `csa_pkg`:
  - state typedef (enum IDLE/ACCUM/RESOLVE/DONE, 2 bits);
  - localparam NCHUNK = LEN/CHUNK;
  - index width $clog2(NCHUNK), minimum 1.
- One sub-module: a single instance of the existing `CSA` (len = LEN) in the ACCUM update path.
- The chunk adder is inline: one CHUNK+1-bit add and a chunk mux/demux by index.
- Elaboration-time check that LEN % CHUNK == 0 and CHUNK ≤ LEN.

## Test plan
- nops=3, ops 1, 2, 3 back-to-back, res_ready_i tied high → res_o = 6, res_valid_o high exactly 5 cycles after the 3rd handshake, one cycle long.
- nops=2, ops 2^128−1 and 1 → res_o = 0 (wrap mod 2^LEN).
- nops=2, ops 0xFFFF_FFFF and 1 → res_o = 0x1_0000_0000 (carry crosses the chunk 0→1 boundary).
- nops=0 → op_ready_o never asserted; res_o = 0 with res_valid_o at t+5.
- Random op_valid_i gaps, 200 random operands, res_ready_i low for 7 cycles after res_valid_o:
  - res_o equals the reference sum mod 2^128 and holds stable while stalled;
  - start_i pulsed while busy is ignored;
  - a second job starts 1 cycle after the result handshake.
- rstn_i asserted mid-ACCUM (after 2 of 4 ops) → all outputs 0 immediately. A subsequent job nops=1, op 0x55 → res_o = 0x55.

Source files
------------

// File: rtl/csa_pkg.sv
// csa_pkg: types and constants used by the csa_acc_ctrl accumulator.
//   state_t    : sequencer states (IDLE/ACCUM/RESOLVE/DONE), 2 bits.
//   DEF_*      : default datapath geometry (128-bit sum, 32-bit chunks).
//   NCHUNK     : number of carry-propagate chunks for the defaults.
//   IDX_W      : chunk index width for the defaults (never less than 1).
//   idx_width(): chunk index width for an arbitrary chunk count.
package csa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DEF_LEN    = 128;
  localparam int DEF_CHUNK  = 32;
  localparam int DEF_NOPS_W = 8;

  localparam int NCHUNK = DEF_LEN / DEF_CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // A single chunk still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_acc_ctrl_csa.sv
// CSA: bitwise 3:2 carry-save adder.
//   a, b, c : three len-bit addends.
//   ps_o    : partial sum  (a ^ b ^ c), same weight as the inputs.
//   sc_o    : carry vector (majority), one bit position more significant
//             than the inputs; the caller applies the shift.
module CSA #(
  parameter int len = 128
) (
  input  logic [len-1:0] a,
  input  logic [len-1:0] b,
  input  logic [len-1:0] c,
  output logic [len-1:0] ps_o,
  output logic [len-1:0] sc_o
);

  assign ps_o = a ^ b ^ c;
  assign sc_o = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_acc_ctrl.sv
// csa_acc_ctrl: accumulates nops operands mod 2^LEN in carry-save form,
// then resolves the redundant sum with a chunked carry-propagate add.
//   clk_i, rstn_i        : clock, asynchronous active-low reset.
//   start_i, nops_i      : job request and operand count (IDLE only).
//   op_valid_i/op_i/op_ready_o   : operand stream handshake (ACCUM only).
//   res_valid_o/res_o/res_ready_i: result handshake (DONE).
//   busy_o               : high in every state except IDLE.
module csa_acc_ctrl
  import csa_pkg::*;
#(
  parameter int LEN    = DEF_LEN,
  parameter int CHUNK  = DEF_CHUNK,
  parameter int NOPS_W = DEF_NOPS_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [NOPS_W-1:0] nops_i,
  input  logic              op_valid_i,
  input  logic [LEN-1:0]    op_i,
  output logic              op_ready_o,
  output logic              res_valid_o,
  output logic [LEN-1:0]    res_o,
  input  logic              res_ready_i,
  output logic              busy_o
);

  localparam int NUM_CHUNKS = LEN / CHUNK;
  localparam int CIDX_W     = idx_width(NUM_CHUNKS);

  generate
    if ((CHUNK < 1) || (CHUNK > LEN) || ((LEN % CHUNK) != 0)) begin : g_bad_cfg
      $error("csa_acc_ctrl: LEN must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t              r_state;
  logic [LEN-1:0]      r_ps;
  logic [LEN-1:0]      r_sc;
  logic [LEN-1:0]      r_res;
  logic                r_res_valid;
  logic [NOPS_W-1:0]   r_rem;
  logic [CIDX_W-1:0]   r_idx;
  logic                r_carry;

  logic [LEN-1:0]      w_ps;
  logic [LEN-1:0]      w_sc;
  logic [CHUNK-1:0]    w_ps_chunk;
  logic [CHUNK-1:0]    w_sc_chunk;
  logic [CHUNK:0]      w_chunk_sum;
  logic                w_last_chunk;

  // Running sum (ps + sc) plus the incoming operand.
  CSA #(.len(LEN)) u_csa (
    .a    (r_ps),
    .b    (r_sc),
    .c    (op_i),
    .ps_o (w_ps),
    .sc_o (w_sc)
  );

  // One CHUNK+1-bit adder shared across all chunks, selected by r_idx.
  assign w_ps_chunk   = r_ps[r_idx*CHUNK +: CHUNK];
  assign w_sc_chunk   = r_sc[r_idx*CHUNK +: CHUNK];
  assign w_chunk_sum  = {1'b0, w_ps_chunk} + {1'b0, w_sc_chunk} + {{CHUNK{1'b0}}, r_carry};
  assign w_last_chunk = (r_idx == CIDX_W'(NUM_CHUNKS - 1));

  // Handshake-side outputs are pure state decodes; the result is registered.
  assign op_ready_o  = (r_state == ST_ACCUM);
  assign busy_o      = (r_state != ST_IDLE);
  assign res_valid_o = r_res_valid;
  assign res_o       = r_res;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values, independent of statement order.
  // NOTE: the wide datapath registers are reset too: a reset must clear res_o
  // to 0 immediately, and ps/sc must start each job from zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      r_ps        <= '0;
      r_sc        <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_rem   <= nops_i;
            r_ps    <= '0;
            r_sc    <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_state <= (nops_i != '0) ? ST_ACCUM : ST_RESOLVE;
          end
        end

        ST_ACCUM: begin
          if (op_valid_i) begin
            r_ps  <= w_ps;
            // Carries weigh one position up; the shift drops bit LEN (mod 2^LEN).
            r_sc  <= w_sc << 1;
            r_rem <= r_rem - NOPS_W'(1);
            if (r_rem == NOPS_W'(1)) begin
              r_idx   <= '0;
              r_carry <= 1'b0;
              r_state <= ST_RESOLVE;
            end
          end
        end

        ST_RESOLVE: begin
          r_res[r_idx*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
          if (w_last_chunk) begin
            // Carry out of the top chunk is beyond 2^LEN and is discarded.
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_carry <= w_chunk_sum[CHUNK];
            r_idx   <= r_idx + CIDX_W'(1);
          end
        end

        ST_DONE: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
            r_ps        <= '0;
            r_sc        <= '0;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_acc_ctrl.sv
// Directed testbench for csa_acc_ctrl (defaults: LEN=128, CHUNK=32, NOPS_W=8).
module tb_csa_acc_ctrl;

  localparam int LEN    = 128;
  localparam int CHUNK  = 32;
  localparam int NOPS_W = 8;

  logic              clk_i;
  logic              rstn_i;
  logic              start_i;
  logic [NOPS_W-1:0] nops_i;
  logic              op_valid_i;
  logic [LEN-1:0]    op_i;
  logic              op_ready_o;
  logic              res_valid_o;
  logic [LEN-1:0]    res_o;
  logic              res_ready_i;
  logic              busy_o;

  int n_checks = 0;
  int n_errors = 0;

  csa_acc_ctrl #(.LEN(LEN), .CHUNK(CHUNK), .NOPS_W(NOPS_W)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .nops_i      (nops_i),
    .op_valid_i  (op_valid_i),
    .op_i        (op_i),
    .op_ready_o  (op_ready_o),
    .res_valid_o (res_valid_o),
    .res_o       (res_o),
    .res_ready_i (res_ready_i),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [LEN-1:0] obs, input logic [LEN-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and samples sit 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one operand and hold it until it is accepted (bounded wait).
  task automatic push_op(input logic [LEN-1:0] v);
    bit done = 1'b0;
    op_valid_i = 1'b1;
    op_i       = v;
    for (int i = 0; i < 20 && !done; i++) begin
      if (op_ready_o) done = 1'b1;
      tick();
    end
    if (!done) check("push_timeout", 0, 1);
  endtask

  // Count cycles until res_valid_o rises; flags any op_ready_o on the way.
  task automatic wait_result(output int cyc, output bit saw_ready);
    cyc = 0;
    saw_ready = 1'b0;
    while (!res_valid_o && cyc < 50) begin
      if (op_ready_o) saw_ready = 1'b1;
      tick();
      cyc++;
    end
    if (!res_valid_o) check("result_timeout", 0, 1);
  endtask

  task automatic start_job(input int n);
    start_i = 1'b1;
    nops_i  = NOPS_W'(n);
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    int            cyc;
    bit            saw_ready;
    logic [LEN-1:0] ref_sum;
    logic [LEN-1:0] v;
    logic [LEN-1:0] held;

    rstn_i      = 1'b0;
    start_i     = 1'b0;
    nops_i      = '0;
    op_valid_i  = 1'b0;
    op_i        = '0;
    res_ready_i = 1'b0;
    #12;
    check("reset_op_ready",  op_ready_o,  0);
    check("reset_res_valid", res_valid_o, 0);
    check("reset_res",       res_o,       0);
    check("reset_busy",      busy_o,      0);
    tick();
    rstn_i = 1'b1;
    tick();

    // Job 1: 1+2+3, back-to-back, consumer always ready.
    res_ready_i = 1'b1;
    start_job(3);
    check("j1_busy_after_start",  busy_o,     1);
    check("j1_ready_after_start", op_ready_o, 1);
    push_op(1);
    push_op(2);
    push_op(3);
    op_valid_i = 1'b0;
    wait_result(cyc, saw_ready);
    // Now in cycle k+1 after the 3rd handshake; valid expected in k+5.
    check("j1_latency", cyc, 4);
    check("j1_res",     res_o, 6);
    tick();
    check("j1_valid_one_cycle", res_valid_o, 0);
    check("j1_idle",            busy_o,      0);

    // Job 2: wrap mod 2^128.
    start_job(2);
    push_op({LEN{1'b1}});
    push_op(1);
    op_valid_i = 1'b0;
    wait_result(cyc, saw_ready);
    check("j2_wrap_res", res_o, 0);
    tick();

    // Job 3: carry across chunk 0 -> 1.
    start_job(2);
    push_op(128'hFFFF_FFFF);
    push_op(1);
    op_valid_i = 1'b0;
    wait_result(cyc, saw_ready);
    check("j3_chunk_carry", res_o, 128'h1_0000_0000);
    tick();

    // Job 4: empty job.
    start_job(0);
    check("j4_busy",     busy_o,     1);
    check("j4_no_ready", op_ready_o, 0);
    wait_result(cyc, saw_ready);
    check("j4_latency",        cyc,       4);
    check("j4_ready_seen",     saw_ready, 0);
    check("j4_res_zero",       res_o,     0);
    tick();

    // Job 5: 200 random operands with random gaps and a stalled consumer.
    res_ready_i = 1'b0;
    ref_sum = '0;
    start_job(200);
    for (int i = 0; i < 200; i++) begin
      op_valid_i = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      if (i == 10) begin
        // Start while busy must not reload the operand count.
        start_i = 1'b1;
        nops_i  = NOPS_W'(3);
        tick();
        start_i = 1'b0;
      end
      v = {$urandom, $urandom, $urandom, $urandom};
      ref_sum = ref_sum + v;
      push_op(v);
    end
    op_valid_i = 1'b0;
    wait_result(cyc, saw_ready);
    check("j5_latency", cyc, 4);
    check("j5_res",     res_o, ref_sum);
    held = res_o;
    for (int s = 0; s < 7; s++) begin
      tick();
      check("j5_stall_valid", res_valid_o, 1);
      check("j5_stall_res",   res_o,       held);
    end
    // Handshake with start_i already high: start must wait for IDLE.
    res_ready_i = 1'b1;
    start_i     = 1'b1;
    nops_i      = NOPS_W'(1);
    tick();
    check("j5_start_not_in_handshake", busy_o, 0);
    tick();
    start_i = 1'b0;
    check("j6_start_turnaround", busy_o,     1);
    check("j6_ready",            op_ready_o, 1);
    push_op(7);
    op_valid_i = 1'b0;
    wait_result(cyc, saw_ready);
    check("j6_res", res_o, 7);
    tick();

    // Reset in the middle of ACCUM.
    start_job(4);
    push_op(100);
    push_op(200);
    op_valid_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    check("rst_busy",      busy_o,      0);
    check("rst_op_ready",  op_ready_o,  0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res",       res_o,       0);
    tick();
    rstn_i = 1'b1;
    tick();
    start_job(1);
    push_op(128'h55);
    op_valid_i = 1'b0;
    wait_result(cyc, saw_ready);
    check("post_rst_res", res_o, 128'h55);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
